// File: rtl/regfile_scan_out.sv
// Serial read-out engine: reads a run of register-file entries through the async read port
// and shifts each one out LSB-first on a TAP-style data line under consumer shift enables.
module regfile_scan_out #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 3
) (
    input  logic              clk,
    input  logic              arst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] first_addr,
    input  logic [ADDR_W:0]   count,
    output logic [ADDR_W-1:0] r_addr,
    input  logic [DATA_W-1:0] r_data,
    input  logic              shift_en,
    output logic              tdo,
    output logic              tdo_valid,
    output logic              busy,
    output logic              done
);

    localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

    typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_t;

    state_t            state_q;
    logic [ADDR_W-1:0] r_addr_q;
    logic [ADDR_W:0]   remaining_q;
    logic [DATA_W-1:0] shreg_q;
    logic [CNT_W-1:0]  bitcnt_q;
    logic              busy_q;
    logic              done_q;

    assign r_addr    = r_addr_q;
    assign busy      = busy_q;
    assign done      = done_q;
    // Zero fill guarantees shreg is 0 outside SHIFT, so tdo needs no state gating.
    assign tdo       = shreg_q[0];
    assign tdo_valid = (state_q == SHIFT);

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state_q     <= IDLE;
            r_addr_q    <= '0;
            remaining_q <= '0;
            shreg_q     <= '0;
            bitcnt_q    <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            // NOTE: every register here uses <= so all of them update from the same pre-edge values.
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        r_addr_q    <= first_addr;
                        remaining_q <= count;
                        busy_q      <= 1'b1;
                        if (count == '0) begin
                            state_q <= DONE;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= LOAD;
                        end
                    end
                end
                LOAD: begin
                    // The entry is sampled here; a same-edge write lands after this capture.
                    shreg_q  <= r_data;
                    bitcnt_q <= '0;
                    state_q  <= SHIFT;
                end
                SHIFT: begin
                    if (shift_en) begin
                        shreg_q  <= shreg_q >> 1;
                        bitcnt_q <= bitcnt_q + CNT_W'(1);
                        if (bitcnt_q == LAST_BIT) begin
                            remaining_q <= remaining_q - (ADDR_W + 1)'(1);
                            r_addr_q    <= r_addr_q + ADDR_W'(1);
                            if (remaining_q == (ADDR_W + 1)'(1)) begin
                                state_q <= DONE;
                                done_q  <= 1'b1;
                            end else begin
                                state_q <= LOAD;
                            end
                        end
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_regfile_scan_out.sv
// Bench for regfile_scan_out: a clocked register-file model feeds the read port, and each run
// is checked against the bit stream expected from the entries, LSB-first, in address order.
module tb_regfile_scan_out;

    logic       clk = 1'b0;
    logic       arst_n;
    logic       start;
    logic [2:0] first_addr;
    logic [3:0] count;
    logic [2:0] r_addr;
    logic [7:0] r_data;
    logic       shift_en;
    logic       tdo;
    logic       tdo_valid;
    logic       busy;
    logic       done;

    logic [7:0] regfile [8];
    logic       we;
    logic [2:0] wa;
    logic [7:0] wd;

    int checks = 0;
    int errors = 0;

    regfile_scan_out #(.DATA_W(8), .ADDR_W(3)) dut (
        .clk       (clk),
        .arst_n    (arst_n),
        .start     (start),
        .first_addr(first_addr),
        .count     (count),
        .r_addr    (r_addr),
        .r_data    (r_data),
        .shift_en  (shift_en),
        .tdo       (tdo),
        .tdo_valid (tdo_valid),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    // Synchronous write port, asynchronous read port.
    always @(posedge clk) if (we) regfile[wa] <= wd;
    assign r_data = regfile[r_addr];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [2:0] a, input logic [7:0] d);
        @(negedge clk);
        we = 1'b1; wa = a; wd = d;
        @(negedge clk);
        we = 1'b0;
    endtask

    function automatic logic [31:0] outs();
        return {27'd0, tdo, tdo_valid, busy, done, 1'b0} | {29'd0, r_addr};
    endfunction

    // mode 0: shift_en always 1 (timing checked); 1: random shift_en; 2: stall 5 then toggle;
    // 3: start pulse injected mid-run; 4: write to the first entry during its LOAD cycle.
    task automatic run(input logic [2:0] fa, input logic [3:0] cnt, input int mode);
        bit         exp_q[$];
        bit         got_q[$];
        logic [7:0] word;
        int cyc = 0, vcnt = 0, loads = 0, first_v = -1, done_cyc = -1, last_cons = -1;
        bit fin = 0, injected = 0, se;
        for (int w = 0; w < int'(cnt); w++) begin
            word = regfile[(int'(fa) + w) % 8];
            for (int b = 0; b < 8; b++) exp_q.push_back(word[b]);
        end
        @(negedge clk);
        start = 1'b1; first_addr = fa; count = cnt; shift_en = 1'b1;
        @(negedge clk);
        start = 1'b0; cyc = 1;
        while (!fin && cyc < 3000) begin
            we = 1'b0;
            start = 1'b0;
            se = (mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
            if (done) begin
                done_cyc = cyc;
                fin = 1;
            end else begin
                if (busy && !tdo_valid) begin
                    chk("r_addr_load", 32'(r_addr), 32'((int'(fa) + loads) % 8));
                    if (mode == 4 && loads == 0) begin
                        we = 1'b1; wa = fa; wd = ~regfile[fa];
                    end
                    loads++;
                end
                if (tdo_valid) begin
                    if (first_v < 0) first_v = cyc;
                    if (got_q.size() < exp_q.size())
                        chk("tdo_bit", 32'(tdo), 32'(exp_q[got_q.size()]));
                    else
                        chk("tdo_extra_bit", 32'(got_q.size()), 32'(exp_q.size() - 1));
                    if (mode == 2) se = (vcnt < 5) ? 1'b0 : ((vcnt - 5) % 2 == 0);
                    if (mode == 3 && vcnt == 3 && !injected) begin
                        injected = 1;
                        start = 1'b1; first_addr = fa + 3'd3; count = 4'd8;
                    end
                    if (se) begin
                        got_q.push_back(tdo);
                        last_cons = cyc;
                    end
                    vcnt++;
                end
            end
            shift_en = se;
            @(negedge clk);
            cyc++;
        end
        we = 1'b0; start = 1'b0;
        chk("run_finished", 32'(fin), 32'd1);
        chk("bits_consumed", 32'(got_q.size()), 32'(exp_q.size()));
        chk("words_loaded", 32'(loads), 32'(cnt));
        if (cnt != 0) chk("done_after_last_bit", 32'(done_cyc), 32'(last_cons + 1));
        if (mode == 0) begin
            chk("done_cycle", 32'(done_cyc), 32'(1 + int'(cnt) * 9));
            chk("valid_cycles", 32'(vcnt), 32'(int'(cnt) * 8));
            if (cnt != 0) chk("first_valid_cycle", 32'(first_v), 32'd2);
        end
        chk("idle_after_done", {29'd0, busy, done, tdo_valid}, 32'd0);
    endtask

    initial begin
        arst_n = 1'b0; start = 1'b0; first_addr = '0; count = '0; shift_en = 1'b0;
        we = 1'b0; wa = '0; wd = '0;
        #1;
        chk("reset_outputs", outs(), 32'd0);
        @(negedge clk);
        arst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            shift_en = 1'($urandom_range(0, 1));
            @(negedge clk);
            chk("idle_no_start", outs(), 32'd0);
        end

        for (int i = 0; i < 8; i++) wr(3'(i), 8'($urandom));
        wr(3'd2, 8'hA5);
        wr(3'd6, 8'h01);
        wr(3'd7, 8'h80);
        wr(3'd0, 8'hFF);

        run(3'd2, 4'd1, 0);            // single word 0xA5
        run(3'd6, 4'd3, 0);            // wrap 6,7,0
        wr(3'd4, 8'h3C);
        run(3'd4, 4'd1, 2);            // backpressure
        run(3'd3, 4'd0, 0);            // count 0
        run(3'd5, 4'd2, 3);            // start ignored while busy
        run(3'd1, 4'd1, 4);            // write during LOAD: old value shifted
        run(3'd1, 4'd1, 0);            // written value now visible
        run(3'd3, 4'd8, 0);            // every entry once

        for (int i = 0; i < 10; i++) begin
            if (i % 3 == 0) wr(3'($urandom_range(0, 7)), 8'($urandom));
            run(3'($urandom_range(0, 7)), 4'($urandom_range(0, 8)), 1);
        end

        // Reset three bits into a four-word run.
        @(negedge clk);
        start = 1'b1; first_addr = 3'd1; count = 4'd4; shift_en = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        #2 arst_n = 1'b0;
        #1;
        chk("midrun_reset_outputs", outs(), 32'd0);
        @(negedge clk);
        chk("reset_held", outs(), 32'd0);
        arst_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("no_resume_after_reset", outs(), 32'd0);
        end
        run(3'd5, 4'd2, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
